irq_pend_arbiter: RTL and testbench

Upstream stage of the interrupt priority mapper. Captures edge-triggered interrupt requests into a pending register and tracks in-service interrupts. A group-serial scan picks the highest-priority candidate, which is the lowest ID that is pending, enabled and not in service. The candidate is presented as the 8-bit encoded ID sel_enc to the priority mapper and the core, with a claim/complete handshake.

---
 rtl/irq_pkg.sv | 24 ++
 rtl/irq_pend_arbiter_if.sv | 29 ++
 rtl/irq_grp_ffs.sv | 27 ++
 rtl/irq_pend_arbiter.sv | 124 ++++++++++++
 tb/tb_irq_pend_arbiter.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
// irq_pkg : shared sizes, IDs and state type for the pending-interrupt arbiter
// Rev 1.0
// ============================================================================
package irq_pkg;

  localparam int ID_W    = 8;
  localparam int NUM_IRQ = 240;
  localparam int GROUP_W = 16;
  localparam int NUM_GRP = NUM_IRQ / GROUP_W;
  localparam int GRP_W   = $clog2(NUM_GRP);
  localparam int IDX_W   = $clog2(GROUP_W);

  localparam logic [ID_W-1:0] IRQ_ID_NONE = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/irq_pend_arbiter_if.sv
`default_nettype none
// ============================================================================
// irq_pend_arbiter_if : request/enable inputs and claim/complete handshake
// Rev 1.0
// ============================================================================
interface irq_pend_arbiter_if;
  import irq_pkg::*;

  logic [NUM_IRQ-1:0] irq_in;
  logic [NUM_IRQ-1:0] irq_en;
  logic               claim;
  logic               complete;
  logic [ID_W-1:0]    complete_id;
  logic [ID_W-1:0]    sel_enc;
  logic               irq_valid;
  logic               irq_req;

  modport master (
    output irq_in, irq_en, claim, complete, complete_id,
    input  sel_enc, irq_valid, irq_req
  );

  modport slave (
    input  irq_in, irq_en, claim, complete, complete_id,
    output sel_enc, irq_valid, irq_req
  );

endinterface
`default_nettype wire

// File: rtl/irq_grp_ffs.sv
`default_nettype none
// ============================================================================
// irq_grp_ffs : combinational find-first-set (lowest index) over one group
// Rev 1.0
// ============================================================================
module irq_grp_ffs
  import irq_pkg::*;
(
  input  logic [GROUP_W-1:0] vec,
  output logic               hit,
  output logic [IDX_W-1:0]   idx
);

  // Walk downward so the lowest set bit is the last one written.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = GROUP_W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/irq_pend_arbiter.sv
`default_nettype none
// ============================================================================
// irq_pend_arbiter : edge capture, in-service tracking and group-serial scan
// Rev 1.0
// ============================================================================
module irq_pend_arbiter
  import irq_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  irq_pend_arbiter_if.slave   bus
);

  generate
    if (NUM_IRQ % GROUP_W != 0) begin : g_bad_group
      $error("NUM_IRQ must be a multiple of GROUP_W");
    end
  endgenerate

  logic [NUM_IRQ-1:0] irq_in_q;
  logic [NUM_IRQ-1:0] irq_en_q;
  logic [NUM_IRQ-1:0] pend;
  logic [NUM_IRQ-1:0] active;
  arb_state_t         state;
  logic [GRP_W-1:0]   grp;
  logic [ID_W-1:0]    sel_enc;
  logic               irq_valid;
  logic               irq_req;

  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] cand;
  logic [NUM_IRQ-1:0] set_mask;
  logic [NUM_IRQ-1:0] cmp_mask;
  logic               claim_acc;
  logic               cmp_acc;
  logic               rs;
  logic               sel_live;
  logic [ID_W-1:0]    grp_base;
  logic [GROUP_W-1:0] grp_vec;
  logic               grp_hit;
  logic [IDX_W-1:0]   grp_idx;

  always_comb begin
    rise      = bus.irq_in & ~irq_in_q;
    cand      = pend & bus.irq_en & ~active;
    claim_acc = bus.claim & irq_valid;
    cmp_acc   = bus.complete && (bus.complete_id < ID_W'(NUM_IRQ))
                && active[bus.complete_id];
    set_mask  = claim_acc ? (NUM_IRQ'(1) << sel_enc) : '0;
    cmp_mask  = cmp_acc ? (NUM_IRQ'(1) << bus.complete_id) : '0;
    rs        = (|rise) | cmp_acc | (bus.irq_en != irq_en_q);
    sel_live  = cand[sel_enc];
    grp_base  = ID_W'(grp) * ID_W'(GROUP_W);
    grp_vec   = cand[grp_base +: GROUP_W];
  end

  irq_grp_ffs u_ffs (
    .vec (grp_vec),
    .hit (grp_hit),
    .idx (grp_idx)
  );

  // A rise on the claimed ID wins over the claim's clear of its pending bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_in_q  <= '0;
      irq_en_q  <= '0;
      pend      <= '0;
      active    <= '0;
      state     <= IDLE;
      grp       <= '0;
      sel_enc   <= IRQ_ID_NONE;
      irq_valid <= 1'b0;
      irq_req   <= 1'b0;
    end else begin
      irq_in_q <= bus.irq_in;
      irq_en_q <= bus.irq_en;
      pend     <= (pend & ~set_mask) | rise;
      active   <= (active & ~cmp_mask) | set_mask;
      irq_req  <= irq_valid;
      case (state)
        IDLE: begin
          if (rs) begin
            state <= SCAN;
            grp   <= '0;
          end
        end
        SCAN: begin
          if (rs) begin
            grp <= '0;
          end else if (grp_hit) begin
            sel_enc   <= grp_base + ID_W'(grp_idx);
            irq_valid <= 1'b1;
            state     <= HOLD;
          end else if (grp == GRP_W'(NUM_GRP - 1)) begin
            state <= IDLE;
          end else begin
            grp <= grp + 1'b1;
          end
        end
        HOLD: begin
          if (claim_acc || rs || !sel_live) begin
            state     <= SCAN;
            grp       <= '0;
            sel_enc   <= IRQ_ID_NONE;
            irq_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          grp       <= '0;
          sel_enc   <= IRQ_ID_NONE;
          irq_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sel_enc   = sel_enc;
  assign bus.irq_valid = irq_valid;
  assign bus.irq_req   = irq_req;

endmodule
`default_nettype wire

// File: tb/tb_irq_pend_arbiter.sv
`default_nettype none
// ============================================================================
// tb_irq_pend_arbiter : directed scenarios plus randomized model comparison
// Rev 1.0
// ============================================================================
module tb_irq_pend_arbiter;
  import irq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;

  irq_pend_arbiter_if bus ();

  irq_pend_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [NUM_IRQ-1:0] en);
    rst = 1'b1;
    bus.irq_in = '0;
    bus.irq_en = '0;
    bus.claim = 1'b0;
    bus.complete = 1'b0;
    bus.complete_id = '0;
    tick();
    tick();
    rst = 1'b0;
    bus.irq_en = en;
    repeat (20) tick();
  endtask

  function automatic int lowest(input logic [NUM_IRQ-1:0] v);
    for (int i = 0; i < NUM_IRQ; i++)
      if (v[i]) return i;
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.irq_in = '0;
    bus.irq_en = '0;
    bus.claim = 1'b0;
    bus.complete = 1'b0;
    bus.complete_id = '0;
    tick();
    n_cmp++; if (bus.sel_enc !== 8'hFF) begin n_fail++; $display("FAIL reset_sel: got %h want ff", bus.sel_enc); end
    n_cmp++; if (bus.irq_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.irq_valid); end
    n_cmp++; if (bus.irq_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", bus.irq_req); end
    n_cmp++; if (dut.pend !== '0) begin n_fail++; $display("FAIL reset_pend: got nonzero want 0"); end
  endtask

  task automatic test_reset_mid_hold();
    bit seen;
    do_reset('1);
    bus.irq_in[5] = 1'b1;
    repeat (2) tick();
    n_cmp++; if (bus.sel_enc !== 8'd5) begin n_fail++; $display("FAIL hold_sel: got %h want 05", bus.sel_enc); end
    #2 rst = 1'b1;
    bus.irq_in = '0;
    #1;
    n_cmp++; if (bus.sel_enc !== 8'hFF) begin n_fail++; $display("FAIL async_rst_sel: got %h want ff", bus.sel_enc); end
    n_cmp++; if (bus.irq_valid !== 1'b0) begin n_fail++; $display("FAIL async_rst_valid: got %b want 0", bus.irq_valid); end
    n_cmp++; if (bus.irq_req !== 1'b0) begin n_fail++; $display("FAIL async_rst_req: got %b want 0", bus.irq_req); end
    tick();
    rst = 1'b0;
    seen = 1'b0;
    repeat (20) begin tick(); if (bus.irq_valid !== 1'b0) seen = 1'b1; end
    n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL post_rst_quiet: got valid=1 want 0"); end
    bus.irq_in[5] = 1'b1;
    repeat (2) tick();
    n_cmp++; if (bus.irq_valid !== 1'b1 || bus.sel_enc !== 8'd5) begin
      n_fail++; $display("FAIL post_rst_rise: got valid=%b sel=%h want 1/05", bus.irq_valid, bus.sel_enc); end
  endtask

  task automatic test_latency();
    int ids [3] = '{5, 37, 239};
    foreach (ids[j]) begin
      int id = ids[j];
      int n = 2 + id / GROUP_W;
      bit early = 1'b0;
      do_reset('1);
      bus.irq_in[id] = 1'b1;
      for (int t = 1; t <= n; t++) begin
        tick();
        if (t < n && bus.irq_valid !== 1'b0) early = 1'b1;
      end
      n_cmp++; if (early !== 1'b0) begin n_fail++; $display("FAIL latency_early id=%0d: got early valid want none", id); end
      n_cmp++; if (bus.irq_valid !== 1'b1 || bus.sel_enc !== ID_W'(id)) begin
        n_fail++; $display("FAIL latency id=%0d: got valid=%b sel=%h want 1/%h", id, bus.irq_valid, bus.sel_enc, ID_W'(id)); end
      tick();
      n_cmp++; if (bus.irq_req !== 1'b1) begin n_fail++; $display("FAIL req_follow id=%0d: got %b want 1", id, bus.irq_req); end
    end
  endtask

  task automatic test_same_cycle();
    do_reset('1);
    bus.irq_in[37] = 1'b1;
    bus.irq_in[5] = 1'b1;
    repeat (2) tick();
    n_cmp++; if (bus.sel_enc !== 8'd5 || bus.irq_valid !== 1'b1) begin
      n_fail++; $display("FAIL dual_rise: got sel=%h valid=%b want 05/1", bus.sel_enc, bus.irq_valid); end
    bus.claim = 1'b1;
    tick();
    bus.claim = 1'b0;
    n_cmp++; if (bus.irq_valid !== 1'b0 || bus.sel_enc !== 8'hFF) begin
      n_fail++; $display("FAIL claim_drop: got sel=%h valid=%b want ff/0", bus.sel_enc, bus.irq_valid); end
    n_cmp++; if (dut.pend[5] !== 1'b0 || dut.active[5] !== 1'b1) begin
      n_fail++; $display("FAIL claim_state: got pend5=%b act5=%b want 0/1", dut.pend[5], dut.active[5]); end
    repeat (3) tick();
    n_cmp++; if (bus.sel_enc !== 8'd37 || bus.irq_valid !== 1'b1) begin
      n_fail++; $display("FAIL next_cand: got sel=%h valid=%b want 25/1", bus.sel_enc, bus.irq_valid); end
  endtask

  task automatic test_active_block();
    bit seen = 1'b0;
    do_reset('1);
    bus.irq_in[5] = 1'b1;
    repeat (2) tick();
    bus.claim = 1'b1;
    tick();
    bus.claim = 1'b0;
    bus.irq_in[5] = 1'b0;
    repeat (20) tick();
    bus.irq_in[5] = 1'b1;
    repeat (20) begin tick(); if (bus.irq_valid !== 1'b0) seen = 1'b1; end
    n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL active_block: got valid=1 want 0"); end
    n_cmp++; if (dut.pend[5] !== 1'b1) begin n_fail++; $display("FAIL active_repend: got %b want 1", dut.pend[5]); end
    bus.complete = 1'b1;
    bus.complete_id = 8'd5;
    tick();
    bus.complete = 1'b0;
    tick();
    n_cmp++; if (bus.sel_enc !== 8'd5 || bus.irq_valid !== 1'b1) begin
      n_fail++; $display("FAIL complete_rescan: got sel=%h valid=%b want 05/1", bus.sel_enc, bus.irq_valid); end
  endtask

  task automatic test_enable();
    logic [NUM_IRQ-1:0] en = '1;
    bit seen = 1'b0;
    en[9] = 1'b0;
    do_reset(en);
    bus.irq_in[9] = 1'b1;
    repeat (20) begin tick(); if (bus.irq_valid !== 1'b0) seen = 1'b1; end
    n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL disabled_sel: got valid=1 want 0"); end
    n_cmp++; if (dut.pend[9] !== 1'b1) begin n_fail++; $display("FAIL disabled_pend: got %b want 1", dut.pend[9]); end
    bus.irq_en[9] = 1'b1;
    repeat (2) tick();
    n_cmp++; if (bus.sel_enc !== 8'd9 || bus.irq_valid !== 1'b1) begin
      n_fail++; $display("FAIL enable_sel: got sel=%h valid=%b want 09/1", bus.sel_enc, bus.irq_valid); end
    bus.irq_en[9] = 1'b0;
    tick();
    n_cmp++; if (bus.sel_enc !== 8'hFF || bus.irq_valid !== 1'b0) begin
      n_fail++; $display("FAIL disable_hold: got sel=%h valid=%b want ff/0", bus.sel_enc, bus.irq_valid); end
  endtask

  task automatic test_claim_collision();
    do_reset('1);
    bus.irq_in[12] = 1'b1;
    repeat (2) tick();
    bus.irq_in[12] = 1'b0;
    tick();
    n_cmp++; if (bus.sel_enc !== 8'd12 || bus.irq_valid !== 1'b1) begin
      n_fail++; $display("FAIL fall_hold: got sel=%h valid=%b want 0c/1", bus.sel_enc, bus.irq_valid); end
    bus.irq_in[12] = 1'b1;
    bus.claim = 1'b1;
    tick();
    bus.claim = 1'b0;
    n_cmp++; if (dut.active[12] !== 1'b1 || dut.pend[12] !== 1'b1) begin
      n_fail++; $display("FAIL rise_wins: got act=%b pend=%b want 1/1", dut.active[12], dut.pend[12]); end
    repeat (20) tick();
    n_cmp++; if (bus.irq_valid !== 1'b0) begin n_fail++; $display("FAIL active_quiet: got %b want 0", bus.irq_valid); end
    bus.complete = 1'b1;
    bus.complete_id = 8'd12;
    tick();
    bus.complete = 1'b0;
    tick();
    n_cmp++; if (bus.sel_enc !== 8'd12 || bus.irq_valid !== 1'b1) begin
      n_fail++; $display("FAIL reselect12: got sel=%h valid=%b want 0c/1", bus.sel_enc, bus.irq_valid); end
    bus.claim = 1'b1;
    tick();
    bus.claim = 1'b0;
    repeat (20) tick();
    bus.claim = 1'b1;
    tick();
    bus.claim = 1'b0;
    n_cmp++; if (bus.irq_valid !== 1'b0 || dut.pend[12] !== 1'b0 || dut.active[12] !== 1'b1) begin
      n_fail++; $display("FAIL idle_claim: got valid=%b pend=%b act=%b want 0/0/1", bus.irq_valid, dut.pend[12], dut.active[12]); end
    bus.complete = 1'b1;
    bus.complete_id = 8'd240;
    tick();
    bus.complete = 1'b0;
    n_cmp++; if (dut.active[12] !== 1'b1 || bus.irq_valid !== 1'b0) begin
      n_fail++; $display("FAIL bad_complete: got act=%b valid=%b want 1/0", dut.active[12], bus.irq_valid); end
  endtask

  // Reference model: pending/in-service sets derived from the input rules only.
  task automatic test_random();
    logic [NUM_IRQ-1:0] m_pend = '0, m_act = '0, m_inq = '0;
    logic [NUM_IRQ-1:0] in_v = '0, en_v = '1, cnd, rise;
    do_reset('1);
    for (int cyc = 0; cyc < 1500; cyc++) begin
      int  exp_id, phase, cid;
      bit  quiet, clm, cmp, v;
      cnd    = m_pend & en_v & ~m_act;
      exp_id = lowest(cnd);
      phase  = cyc % 50;
      quiet  = (phase >= 30);
      v      = bus.irq_valid;
      if (v) begin
        n_cmp++; if (exp_id < 0 || bus.sel_enc !== ID_W'(exp_id)) begin
          n_fail++; $display("FAIL rand_sel cyc=%0d: got %h want %0d", cyc, bus.sel_enc, exp_id); end
      end
      if (phase == 49) begin
        n_cmp++; if (v !== (exp_id >= 0)) begin
          n_fail++; $display("FAIL rand_settle cyc=%0d: got valid=%b want %b", cyc, v, exp_id >= 0); end
      end
      clm = 1'b0; cmp = 1'b0; cid = 0;
      if (!quiet) begin
        for (int k = 0; k < 2; k++)
          if ($urandom % 4 == 0) in_v[($urandom % 24) * 10] ^= 1'b1;
        if ($urandom % 16 == 0) en_v[($urandom % 24) * 10] ^= 1'b1;
        clm = v ? ($urandom % 3 == 0) : ($urandom % 8 == 0);
        if ($urandom % 5 == 0) begin
          cmp = 1'b1;
          cid = ($urandom % 6 == 0) ? 240 + int'($urandom % 16) : int'(($urandom % 24) * 10);
        end
      end
      rise = in_v & ~m_inq;
      if (cmp && cid < NUM_IRQ && m_act[cid]) m_act[cid] = 1'b0;
      if (clm && v && exp_id >= 0) begin
        m_pend[exp_id] = 1'b0;
        m_act[exp_id] = 1'b1;
      end
      m_pend = m_pend | rise;
      m_inq  = in_v;
      bus.irq_in = in_v;
      bus.irq_en = en_v;
      bus.claim = clm;
      bus.complete = cmp;
      bus.complete_id = ID_W'(cid);
      tick();
    end
    bus.claim = 1'b0;
    bus.complete = 1'b0;
  endtask

  initial begin
    test_reset();
    test_reset_mid_hold();
    test_latency();
    test_same_cycle();
    test_active_block();
    test_enable();
    test_claim_collision();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
